// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module : mole_scheduler
// Whack-a-mole sequencer: LFSR mole pick, fixed lit/dark windows, hit scoring.
// Rev    : 1.0
// ============================================================================
module mole_scheduler #(
  parameter int MOLE_ON_CYCLES = 100000000,
  parameter int GAP_CYCLES     = 25000000,
  parameter int ROUNDS         = 20
) (
  input  logic       cin,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] hit_btn,
  output logic [8:0] mole_led,
  output logic [6:0] score,
  output logic [7:0] round_cnt,
  output logic       busy,
  output logic       game_over
);

  localparam int TMAX = (MOLE_ON_CYCLES > GAP_CYCLES) ? MOLE_ON_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] UP_LAST   = TW'(MOLE_ON_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [7:0]    ROUNDS_C  = 8'(ROUNDS);
  localparam logic [6:0]    SCORE_MAX = 7'd99;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          start_hist_q, start_hist_d;
  logic [8:0]    hit_hist_q, hit_hist_d;
  logic [3:0]    last_idx_q, last_idx_d;
  logic [8:0]    mole_led_q, mole_led_d;
  logic [6:0]    score_q, score_d;
  logic [7:0]    round_cnt_q, round_cnt_d;
  logic          busy_q, busy_d;
  logic          game_over_q, game_over_d;

  logic          start_rise;
  logic [8:0]    hit_rise;
  logic          mole_hit;
  logic [3:0]    cand;
  logic [3:0]    next_idx;

  always_comb begin
    start_rise = start & ~start_hist_q;
    hit_rise   = hit_btn & ~hit_hist_q;
    // mole_led is one-hot in UP, so masking with it selects the active button
    mole_hit   = |(hit_rise & mole_led_q);
    cand       = 4'(lfsr_q % 8'd9);
    if (cand == last_idx_q) begin
      next_idx = (cand == 4'd8) ? 4'd0 : cand + 4'd1;
    end else begin
      next_idx = cand;
    end
  end

  always_comb begin
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    start_hist_d = start;
    hit_hist_d   = hit_btn;
    state_d      = state_q;
    timer_d      = timer_q + TIMER_ONE;
    last_idx_d   = last_idx_q;
    mole_led_d   = mole_led_q;
    score_d      = score_q;
    round_cnt_d  = round_cnt_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        timer_d    = '0;
        mole_led_d = '0;
        if (start_rise) begin
          score_d     = '0;
          round_cnt_d = '0;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (round_cnt_q == ROUNDS_C) begin
            state_d = S_OVER;
          end else begin
            state_d     = S_UP;
            mole_led_d  = 9'(1) << next_idx;
            last_idx_d  = next_idx;
            round_cnt_d = round_cnt_q + 8'd1;
          end
        end
      end
      S_UP: begin
        // a hit on the timeout cycle still scores
        if (mole_hit) begin
          timer_d    = '0;
          state_d    = S_GAP;
          mole_led_d = '0;
          score_d    = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 7'd1;
        end else if (timer_q == UP_LAST) begin
          timer_d    = '0;
          state_d    = S_GAP;
          mole_led_d = '0;
        end
      end
      default: begin
        timer_d    = '0;
        state_d    = S_IDLE;
        mole_led_d = '0;
      end
    endcase

    busy_d      = (state_d == S_GAP) || (state_d == S_UP);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      lfsr_q       <= 8'h01;
      start_hist_q <= 1'b0;
      hit_hist_q   <= '0;
      last_idx_q   <= '0;
      mole_led_q   <= '0;
      score_q      <= '0;
      round_cnt_q  <= '0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lfsr_q       <= lfsr_d;
      start_hist_q <= start_hist_d;
      hit_hist_q   <= hit_hist_d;
      last_idx_q   <= last_idx_d;
      mole_led_q   <= mole_led_d;
      score_q      <= score_d;
      round_cnt_q  <= round_cnt_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
    end
  end

  assign mole_led  = mole_led_q;
  assign score     = score_q;
  assign round_cnt = round_cnt_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;

endmodule
`default_nettype wire
